sd_transfer_arbiter: RTL and testbench

//  Shares the single SD SPI interface between two requesters: USB bulk-OUT (SD write) and USB bulk-IN (SD read).

---
 rtl/sd_transfer_arbiter.sv | 157 +++++++++++++++
 tb/tb_sd_transfer_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_transfer_arbiter.sv
// sd_transfer_arbiter
//   Shares the single SD SPI interface between the USB bulk-OUT path (SD
//   write) and the USB bulk-IN path (SD read). One requester is granted at a
//   time, and its multi-block transfer is sequenced with one sd_write/sd_read
//   pulse per block. Each block is guarded by a watchdog. The arbiter reports
//   the end of a transfer with either xfer_done or xfer_err.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   wr_req, wr_nblk          write request (level) and block count (sampled at grant)
//   rd_req, rd_nblk          read request (level) and block count (sampled at grant)
//   spi_init_done            SD card initialised (level)
//   sd_write_done            one-cycle pulse from the SD core: one block written
//   sd_read_done             one-cycle pulse from the SD core: one block read
//   sd_write, sd_read        one-cycle pulses that start one block
//   wr_grant, rd_grant       ownership of the SD interface
//   blk_remaining            blocks still outstanding in the current transfer
//   xfer_done, xfer_err      one-cycle completion / abort pulses
module sd_transfer_arbiter #(
  parameter int BLK_W       = 8,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int TMR_W       = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  input  logic [BLK_W-1:0] wr_nblk,
  input  logic             rd_req,
  input  logic [BLK_W-1:0] rd_nblk,
  input  logic             spi_init_done,
  input  logic             sd_write_done,
  input  logic             sd_read_done,
  output logic             sd_write,
  output logic             sd_read,
  output logic             wr_grant,
  output logic             rd_grant,
  output logic [BLK_W-1:0] blk_remaining,
  output logic             xfer_done,
  output logic             xfer_err
);

  typedef enum logic [2:0] {
    IDLE, WR_START, WR_WAIT, RD_START, RD_WAIT, DONE, ERR
  } state_t;

  // The watchdog aborts on the edge where its count would reach this value.
  localparam logic [TMR_W-1:0] WD_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_t           state, state_nxt;
  logic [BLK_W-1:0] blk_nxt;
  logic [TMR_W-1:0] wd, wd_nxt, wd_inc;
  logic             last_wr, last_wr_nxt;
  logic             pick_wr, blk_done;
  logic             wr_grant_nxt, rd_grant_nxt;
  logic             sd_write_nxt, sd_read_nxt;
  logic             xfer_done_nxt, xfer_err_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      blk_remaining <= '0;
      wd            <= '0;
      last_wr       <= 1'b0;
      wr_grant      <= 1'b0;
      rd_grant      <= 1'b0;
      sd_write      <= 1'b0;
      sd_read       <= 1'b0;
      xfer_done     <= 1'b0;
      xfer_err      <= 1'b0;
    end else begin
      state         <= state_nxt;
      blk_remaining <= blk_nxt;
      wd            <= wd_nxt;
      last_wr       <= last_wr_nxt;
      wr_grant      <= wr_grant_nxt;
      rd_grant      <= rd_grant_nxt;
      sd_write      <= sd_write_nxt;
      sd_read       <= sd_read_nxt;
      xfer_done     <= xfer_done_nxt;
      xfer_err      <= xfer_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    blk_nxt       = blk_remaining;
    wd_nxt        = wd;
    wd_inc        = wd + TMR_W'(1);
    last_wr_nxt   = last_wr;
    wr_grant_nxt  = wr_grant;
    rd_grant_nxt  = rd_grant;
    sd_write_nxt  = 1'b0;
    sd_read_nxt   = 1'b0;
    xfer_done_nxt = 1'b0;
    xfer_err_nxt  = 1'b0;
    blk_done      = 1'b0;
    // On a tie, the direction that was not served last wins.
    pick_wr       = wr_req && (!rd_req || !last_wr);

    case (state)
      IDLE: begin
        if (spi_init_done && (wr_req || rd_req)) begin
          last_wr_nxt  = pick_wr;
          wr_grant_nxt = pick_wr;
          rd_grant_nxt = !pick_wr;
          blk_nxt      = pick_wr ? wr_nblk : rd_nblk;
          if (blk_nxt == '0)
            state_nxt = DONE;
          else
            state_nxt = pick_wr ? WR_START : RD_START;
        end
      end
      WR_START, RD_START: begin
        if (!spi_init_done) begin
          state_nxt = ERR;
        end else begin
          sd_write_nxt = (state == WR_START);
          sd_read_nxt  = (state == RD_START);
          wd_nxt       = '0;
          state_nxt    = (state == WR_START) ? WR_WAIT : RD_WAIT;
        end
      end
      WR_WAIT, RD_WAIT: begin
        blk_done = (state == WR_WAIT) ? sd_write_done : sd_read_done;
        if (!spi_init_done) begin
          state_nxt = ERR;
        end else if (blk_done && blk_remaining != '0) begin
          // A completion that coincides with the timeout edge still counts.
          blk_nxt = blk_remaining - BLK_W'(1);
          if (blk_nxt == '0)
            state_nxt = DONE;
          else
            state_nxt = (state == WR_WAIT) ? WR_START : RD_START;
        end else if (wd_inc == WD_LAST) begin
          state_nxt = ERR;
        end else begin
          wd_nxt = wd_inc;
        end
      end
      DONE: begin
        xfer_done_nxt = 1'b1;
        wr_grant_nxt  = 1'b0;
        rd_grant_nxt  = 1'b0;
        state_nxt     = IDLE;
      end
      ERR: begin
        // blk_remaining is left holding the unfinished count.
        xfer_err_nxt = 1'b1;
        wr_grant_nxt = 1'b0;
        rd_grant_nxt = 1'b0;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sd_transfer_arbiter.sv
// tb_sd_transfer_arbiter
//   Testbench for sd_transfer_arbiter. Directed scenarios are followed by
//   randomized transfers. The bench plays both requesters and the SD core.
//   Every observed output is compared with a transaction-level expectation,
//   which is built from the grant order, the block count, the response delay
//   and the abort cause.
module tb_sd_transfer_arbiter;
  localparam int BLK_W = 8;
  localparam int TO    = 16;
  localparam int TMR_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_req = 1'b0, rd_req = 1'b0;
  logic [BLK_W-1:0] wr_nblk = '0, rd_nblk = '0;
  logic             spi_init_done = 1'b1;
  logic             sd_write_done = 1'b0, sd_read_done = 1'b0;
  logic             sd_write, sd_read, wr_grant, rd_grant, xfer_done, xfer_err;
  logic [BLK_W-1:0] blk_remaining;

  int n_cmp = 0;
  int n_mis = 0;
  int fix_delay = 0;
  bit last_wr = 1'b0;   // model: last served direction was write

  sd_transfer_arbiter #(.BLK_W(BLK_W), .TIMEOUT_CYC(TO), .TMR_W(TMR_W)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_nblk(wr_nblk), .rd_req(rd_req), .rd_nblk(rd_nblk),
    .spi_init_done(spi_init_done),
    .sd_write_done(sd_write_done), .sd_read_done(sd_read_done),
    .sd_write(sd_write), .sd_read(sd_read),
    .wr_grant(wr_grant), .rd_grant(rd_grant),
    .blk_remaining(blk_remaining),
    .xfer_done(xfer_done), .xfer_err(xfer_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sd_write_done = 1'b0;
    sd_read_done  = 1'b0;
    chk("grant_excl", 32'(wr_grant & rd_grant), 32'(0));
  endtask

  task automatic release_req(input bit dw);
    if (dw) wr_req = 1'b0;
    else    rd_req = 1'b0;
  endtask

  // Done pulses for the direction that does not own the interface.
  task automatic noise(input bit dw);
    if (dw) sd_read_done  = ($urandom % 3 == 0);
    else    sd_write_done = ($urandom % 3 == 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 32'({sd_write, sd_read, wr_grant, rd_grant, xfer_done, xfer_err}), 32'(0));
    chk({tag, "_blk"}, 32'(blk_remaining), 32'(0));
  endtask

  // Entered in the cycle where the grant is visible. Returns in the
  // xfer_done/xfer_err cycle with the served request released.
  task automatic serve(input bit dw, input int n, input int stall, input int kill);
    int d;
    chk("wr_grant", 32'(wr_grant), 32'(dw));
    chk("rd_grant", 32'(rd_grant), 32'(!dw));
    chk("blk_grant", 32'(blk_remaining), 32'(n));
    if (n == 0) begin
      tick();
      chk("done_nblk0", 32'(xfer_done), 32'(1));
      chk("pulse_nblk0", 32'({sd_write, sd_read}), 32'(0));
      chk("grant_drop0", 32'({wr_grant, rd_grant}), 32'(0));
      release_req(dw);
      return;
    end
    for (int b = 0; b < n; b++) begin
      tick();
      chk("pulse", 32'(dw ? sd_write : sd_read), 32'(1));
      chk("pulse_other", 32'(dw ? sd_read : sd_write), 32'(0));
      chk("blk_pulse", 32'(blk_remaining), 32'(n - b));
      if (b == kill) begin
        tick();
        tick();
        spi_init_done = 1'b0;
        tick();
        chk("err_kill_early", 32'(xfer_err), 32'(0));
        tick();
        chk("err_kill", 32'(xfer_err), 32'(1));
        chk("blk_kill", 32'(blk_remaining), 32'(n - b));
        chk("grant_kill", 32'({wr_grant, rd_grant}), 32'(0));
        spi_init_done = 1'b1;
        release_req(dw);
        return;
      end
      if (b == stall) begin
        for (int i = 1; i <= TO; i++) begin
          noise(dw);
          tick();
          chk("err_timeout", 32'(xfer_err), 32'(i == TO));
        end
        chk("blk_timeout", 32'(blk_remaining), 32'(n - b));
        chk("grant_timeout", 32'({wr_grant, rd_grant}), 32'(0));
        release_req(dw);
        return;
      end
      d = (fix_delay != 0) ? fix_delay : $urandom_range(1, TO - 2);
      for (int i = 1; i <= d; i++) begin
        noise(dw);
        tick();
        chk("quiet_wait", 32'({sd_write, sd_read, xfer_done, xfer_err}), 32'(0));
      end
      if (dw) sd_write_done = 1'b1;
      else    sd_read_done  = 1'b1;
      tick();
      chk("blk_dec", 32'(blk_remaining), 32'(n - b - 1));
      chk("no_done_yet", 32'({xfer_done, sd_write, sd_read}), 32'(0));
      if (b == n - 1) begin
        tick();
        chk("xfer_done", 32'(xfer_done), 32'(1));
        chk("xfer_err_clear", 32'(xfer_err), 32'(0));
        chk("grant_drop", 32'({wr_grant, rd_grant}), 32'(0));
        chk("blk_end", 32'(blk_remaining), 32'(0));
        release_req(dw);
        return;
      end
      // A done pulse for the granted direction while it is starting the next block must be ignored.
      if ($urandom_range(0, 1) == 1) begin
        if (dw) sd_write_done = 1'b1;
        else    sd_read_done  = 1'b1;
      end
    end
  endtask

  task automatic run(input bit w, input bit r, input int wn, input int rn,
                     input int stall, input int kill);
    bit first;
    int g;
    wr_nblk = BLK_W'(wn);
    rd_nblk = BLK_W'(rn);
    wr_req  = w;
    rd_req  = r;
    tick();
    first   = (w && r) ? !last_wr : w;
    last_wr = first;
    serve(first, first ? wn : rn, stall, kill);
    if (w && r) begin
      tick();
      last_wr = !first;
      serve(!first, first ? rn : wn, -1, -1);
    end
    g = $urandom_range(0, 3);
    for (int i = 0; i < g; i++) begin
      tick();
      chk("idle_grant", 32'({wr_grant, rd_grant}), 32'(0));
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int pat, stall, kill, sel;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk_all_zero("post_reset");

    // Simultaneous requests after reset: write first, then read.
    run(1'b1, 1'b1, 1, 1, -1, -1);
    // Three-block write, core answers 10 cycles after each pulse.
    fix_delay = 10;
    run(1'b1, 1'b0, 3, 0, -1, -1);
    fix_delay = 0;
    // Two-block read, second completion withheld.
    run(1'b0, 1'b1, 0, 2, 1, -1);
    // Zero-block write.
    run(1'b1, 1'b0, 0, 0, -1, -1);

    // Read requested before the card is ready.
    spi_init_done = 1'b0;
    rd_nblk = BLK_W'(1);
    rd_req  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_grant_uninit", 32'({wr_grant, rd_grant}), 32'(0));
    end
    spi_init_done = 1'b1;
    tick();
    last_wr = 1'b0;
    serve(1'b0, 1, -1, -1);

    // Card drops out during the second block.
    run(1'b1, 1'b0, 3, 0, -1, 1);
    // Completion arriving on the last cycle before the timeout.
    fix_delay = TO - 2;
    run(1'b0, 1'b1, 0, 1, -1, -1);
    fix_delay = 0;

    // Asynchronous reset in the middle of a write.
    wr_nblk = BLK_W'(2);
    wr_req  = 1'b1;
    tick();
    tick();
    chk("pre_rst_pulse", 32'(sd_write), 32'(1));
    tick();
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    wr_req = 1'b0;
    tick();
    rst = 1'b0;
    last_wr = 1'b0;
    tick();
    chk_all_zero("after_reset");
    run(1'b1, 1'b0, 2, 0, -1, -1);

    // Randomized transfers.
    for (int it = 0; it < 40; it++) begin
      pat   = $urandom_range(0, 2);
      sel   = $urandom_range(0, 9);
      stall = (sel == 0) ? $urandom_range(0, 3) : -1;
      kill  = (sel == 1) ? $urandom_range(0, 3) : -1;
      run(pat != 1, pat != 0, $urandom_range(0, 4), $urandom_range(0, 4), stall, kill);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
